// File: rtl/interp_pkg.sv
// Shared definitions for the linear interpolating upsampler: the FSM state
// encoding and the default parameter values used by the top and sub-module.
package interp_pkg;

    localparam int DEF_IN_WIDTH    = 16;
    localparam int DEF_LOG2_FACTOR = 3;

    // IDLE: nothing held; WAIT: endpoint A held; RUN: segment A->B running.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/interp_segment_accumulator.sv
// Segment accumulator. It holds A scaled by 2^LOG2_FACTOR and adds (B-A) once
// per output phase. The output is the accumulator shifted right arithmetically
// by LOG2_FACTOR, which gives A + floor((B-A)*k/N). One sign bit of headroom on
// the difference and LOG2_FACTOR bits on the accumulator keep every
// intermediate value in range for any pair of full-scale signed samples.
module interp_segment_accumulator
    import interp_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int LOG2_FACTOR = DEF_LOG2_FACTOR
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_load,
    input  logic                       i_step,
    input  logic signed [IN_WIDTH-1:0] i_a,
    input  logic signed [IN_WIDTH-1:0] i_b,
    output logic signed [IN_WIDTH-1:0] o_sample
);

    localparam int DIFF_W = IN_WIDTH + 1;
    localparam int ACC_W  = IN_WIDTH + 1 + LOG2_FACTOR;

    logic signed [DIFF_W-1:0] w_a_ext;
    logic signed [DIFF_W-1:0] w_b_ext;
    logic signed [DIFF_W-1:0] w_diff;
    logic signed [ACC_W-1:0]  w_load_val;
    logic signed [ACC_W-1:0]  w_diff_ext;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DIFF_W-1:0] r_diff;

    assign w_a_ext    = {i_a[IN_WIDTH-1], i_a};
    assign w_b_ext    = {i_b[IN_WIDTH-1], i_b};
    assign w_diff     = w_b_ext - w_a_ext;
    assign w_load_val = {i_a[IN_WIDTH-1], i_a, {LOG2_FACTOR{1'b0}}};
    assign w_diff_ext = {{LOG2_FACTOR{r_diff[DIFF_W-1]}}, r_diff};

    // Load a new segment (A<<L and B-A) or advance one phase; load wins.
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc  <= '0;
            r_diff <= '0;
        end else if (i_load) begin
            r_acc  <= w_load_val;
            r_diff <= w_diff;
        end else if (i_step) begin
            r_acc  <= r_acc + w_diff_ext;
        end
    end

    // The shifted value always lies between A and B, so taking this slice is
    // the same as an arithmetic shift followed by truncation.
    assign o_sample = r_acc[LOG2_FACTOR +: IN_WIDTH];

endmodule

// File: rtl/linear_interp_upsampler.sv
// Linear interpolating upsampler by N = 2^LOG2_FACTOR. It accepts low-rate
// samples through a valid/ready handshake. For each pair of endpoints A->B it
// emits N strobed samples. A one-entry buffer lets the next endpoint arrive
// while a segment runs, so back-to-back input gives a gap-free output stream.
module linear_interp_upsampler
    import interp_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int LOG2_FACTOR = DEF_LOG2_FACTOR
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [IN_WIDTH-1:0] in_sample,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [IN_WIDTH-1:0] out_sample,
    output logic                       out_strobe,
    output logic                       underrun
);

    localparam logic [LOG2_FACTOR-1:0] K_LAST = '1;
    localparam logic [LOG2_FACTOR-1:0] K_ONE  = LOG2_FACTOR'(1);

    state_t                      r_state;
    logic signed [IN_WIDTH-1:0]  r_a;
    logic signed [IN_WIDTH-1:0]  r_b;
    logic signed [IN_WIDTH-1:0]  r_buf;
    logic                        r_buf_full;
    logic [LOG2_FACTOR-1:0]      r_k;
    logic                        r_out_strobe;
    logic                        r_underrun;

    state_t                      w_state_nxt;
    logic signed [IN_WIDTH-1:0]  w_a_nxt;
    logic signed [IN_WIDTH-1:0]  w_b_nxt;
    logic signed [IN_WIDTH-1:0]  w_buf_nxt;
    logic                        w_buf_full_nxt;
    logic [LOG2_FACTOR-1:0]      w_k_nxt;
    logic                        w_underrun_nxt;
    logic                        w_load;
    logic                        w_step;
    logic signed [IN_WIDTH-1:0]  w_load_a;
    logic signed [IN_WIDTH-1:0]  w_load_b;
    logic                        w_last;
    logic                        w_ready;
    logic                        w_xfer;

    assign w_last  = (r_k == K_LAST);
    // In RUN, a sample can be taken if the buffer is empty, or on the last
    // phase, when the buffer drains into B on the same edge.
    assign w_ready = (r_state != ST_RUN) || !r_buf_full || w_last;
    assign w_xfer  = in_valid && w_ready;

    // Next-state, endpoint/buffer updates and accumulator control.
    // NOTE: every signal gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_buf_nxt      = r_buf;
        w_buf_full_nxt = r_buf_full;
        w_k_nxt        = r_k;
        w_underrun_nxt = 1'b0;
        w_load         = 1'b0;
        w_step         = 1'b0;
        w_load_a       = r_b;
        w_load_b       = in_sample;

        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    // Hold A with a zero slope so that WAIT shows A.
                    w_load      = 1'b1;
                    w_load_a    = in_sample;
                    w_load_b    = in_sample;
                    w_a_nxt     = in_sample;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_xfer) begin
                    w_load      = 1'b1;
                    w_load_a    = r_a;
                    w_load_b    = in_sample;
                    w_b_nxt     = in_sample;
                    w_k_nxt     = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_last) begin
                    w_step  = 1'b1;
                    w_k_nxt = r_k + K_ONE;
                    if (w_xfer) begin
                        w_buf_nxt      = in_sample;
                        w_buf_full_nxt = 1'b1;
                    end
                end else if (r_buf_full || w_xfer) begin
                    // Chain straight into the next segment B->next.
                    w_load   = 1'b1;
                    w_load_a = r_b;
                    w_load_b = r_buf_full ? r_buf : in_sample;
                    w_a_nxt  = r_b;
                    w_b_nxt  = w_load_b;
                    w_k_nxt  = '0;
                    if (r_buf_full) begin
                        w_buf_full_nxt = w_xfer;
                        if (w_xfer) begin
                            w_buf_nxt = in_sample;
                        end
                    end
                end else begin
                    // The final step lands the accumulator exactly on B.
                    w_step         = 1'b1;
                    w_a_nxt        = r_b;
                    w_underrun_nxt = 1'b1;
                    w_state_nxt    = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register, endpoints, buffer and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_buf        <= '0;
            r_buf_full   <= 1'b0;
            r_k          <= '0;
            r_out_strobe <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_a          <= w_a_nxt;
            r_b          <= w_b_nxt;
            r_buf        <= w_buf_nxt;
            r_buf_full   <= w_buf_full_nxt;
            r_k          <= w_k_nxt;
            r_out_strobe <= (w_state_nxt == ST_RUN);
            r_underrun   <= w_underrun_nxt;
        end
    end

    interp_segment_accumulator #(
        .IN_WIDTH    (IN_WIDTH),
        .LOG2_FACTOR (LOG2_FACTOR)
    ) u_acc (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_a      (w_load_a),
        .i_b      (w_load_b),
        .o_sample (out_sample)
    );

    assign in_ready   = w_ready;
    assign out_strobe = r_out_strobe;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_linear_interp_upsampler.sv
// Testbench for linear_interp_upsampler (IN_WIDTH=16, N=8). A behavioural
// model tracks the endpoints, the phase and a queue of pending samples. It
// predicts each output directly from A + floor((B-A)*k/N). Directed
// sequences cover the reset, ramp, rounding, full-scale, underrun and
// mid-segment reset cases, and random traffic follows them.
module tb_linear_interp_upsampler;

    localparam int W  = 16;
    localparam int L2 = 3;
    localparam int N  = 1 << L2;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic signed [W-1:0] in_sample = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] out_sample;
    logic                out_strobe;
    logic                underrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_mode = M_IDLE;
    int m_a = 0;
    int m_b = 0;
    int m_k = 0;
    int m_q[$];
    bit m_und = 1'b0;

    int tx_q[$];
    int cap_q[$];
    int und_seen = 0;
    bit last_xfer = 1'b0;

    linear_interp_upsampler #(
        .IN_WIDTH    (W),
        .LOG2_FACTOR (L2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sample (out_sample),
        .out_strobe (out_strobe),
        .underrun   (underrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint num, input longint den);
        if (num >= 0) return num / den;
        return -((-num + den - 1) / den);
    endfunction

    function automatic int model_out();
        if (m_mode == M_IDLE) return 0;
        if (m_mode == M_WAIT) return m_a;
        return int'(longint'(m_a) + floor_div((longint'(m_b) - longint'(m_a)) * m_k, N));
    endfunction

    // One clock cycle: drive, check ready, advance model, check outputs.
    task automatic step(input bit rst, input bit v, input int d);
        bit ready;
        bit xfer;
        reset     = rst;
        in_valid  = v;
        in_sample = W'(d);
        ready = (m_mode != M_RUN) || (m_q.size() == 0) || (m_k == N - 1);
        check("in_ready", in_ready, ready);
        xfer = v && ready && !rst;
        @(posedge clock);
        m_und = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_a = 0; m_b = 0; m_k = 0;
            m_q.delete();
        end else begin
            case (m_mode)
                M_IDLE: if (xfer) begin m_a = d; m_mode = M_WAIT; end
                M_WAIT: if (xfer) begin m_b = d; m_k = 0; m_mode = M_RUN; end
                default: begin
                    if (m_k < N - 1) begin
                        m_k++;
                        if (xfer) m_q.push_back(d);
                    end else if (m_q.size() > 0 || xfer) begin
                        m_a = m_b;
                        if (m_q.size() > 0) begin
                            m_b = m_q.pop_front();
                            if (xfer) m_q.push_back(d);
                        end else begin
                            m_b = d;
                        end
                        m_k = 0;
                    end else begin
                        m_a = m_b;
                        m_mode = M_WAIT;
                        m_und = 1'b1;
                    end
                end
            endcase
        end
        last_xfer = xfer;
        @(negedge clock);
        check("out_sample", out_sample, model_out());
        check("out_strobe", out_strobe, (m_mode == M_RUN));
        check("underrun", underrun, m_und);
        if (out_strobe === 1'b1) cap_q.push_back(int'(out_sample));
        if (underrun === 1'b1) und_seen++;
    endtask

    // Offer queued samples for n cycles, with valid asserted pct% of the time.
    task automatic drive(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            if (tx_q.size() > 0 && $urandom_range(99) < pct) begin
                step(1'b0, 1'b1, tx_q[0]);
                if (last_xfer) void'(tx_q.pop_front());
            end else begin
                step(1'b0, 1'b0, int'($urandom_range(65535)) - 32768);
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
        tx_q.delete();
        cap_q.delete();
        und_seen = 0;
    endtask

    task automatic check_cap(input string tag, input int exp[]);
        check({tag, "_len"}, cap_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
            check(tag, cap_q[i], exp[i]);
    endtask

    initial begin
        int exp_ramp[];
        int exp_neg[];
        int exp_re[];
        int guard;

        @(negedge clock);

        // Reset held for 3 cycles, then idle.
        do_reset(3);
        step(1'b0, 1'b0, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_in_ready", in_ready, 1);

        // 0, 800, 800 back to back: ramp then flat, gap-free strobe.
        tx_q = '{0, 800, 800};
        drive(22, 100);
        exp_ramp = new[16];
        for (int i = 0; i < 8; i++) exp_ramp[i] = 100 * i;
        for (int i = 8; i < 16; i++) exp_ramp[i] = 800;
        check_cap("ramp", exp_ramp);
        check("ramp_underrun_once", und_seen, 1);

        // Floor rounding on a small negative slope.
        do_reset(1);
        tx_q = '{0, -3};
        drive(12, 100);
        exp_neg = '{0, -1, -1, -2, -2, -2, -3, -3};
        check_cap("floor", exp_neg);

        // Full-scale segment must not wrap.
        do_reset(1);
        tx_q = '{-32768, 32767};
        drive(12, 100);
        check("fullscale_len", cap_q.size(), 8);
        if (cap_q.size() == 8) check("fullscale_k7", cap_q[7], 24575);

        // Underrun, then resume from WAIT.
        do_reset(1);
        tx_q = '{100, 200};
        drive(12, 100);
        check("und_count", und_seen, 1);
        check("und_hold", out_sample, 200);
        check("und_strobe", out_strobe, 0);
        step(1'b0, 1'b1, 0);
        check("resume_out", out_sample, 200);
        check("resume_strobe", out_strobe, 1);

        // Reset at k=4 with the buffer full, then restart.
        do_reset(1);
        tx_q = '{10, 20, 30};
        guard = 0;
        while (!(m_mode == M_RUN && m_k == 4 && m_q.size() == 1) && guard < 20) begin
            drive(1, 100);
            guard++;
        end
        check("reach_k4_full", (guard < 20), 1);
        step(1'b1, 1'b0, 0);
        check("midrst_out", out_sample, 0);
        check("midrst_strobe", out_strobe, 0);
        tx_q.delete();
        cap_q.delete();
        step(1'b0, 1'b0, 0);
        check("midrst_ready", in_ready, 1);
        tx_q = '{5, 13};
        drive(12, 100);
        exp_re = '{5, 6, 7, 8, 9, 10, 11, 12};
        check_cap("restart", exp_re);

        // Random traffic, including full-scale extremes and varying valid density.
        do_reset(1);
        for (int c = 0; c < 20; c++) begin
            for (int j = 0; j < 15; j++) begin
                case ($urandom_range(9))
                    0: tx_q.push_back(-32768);
                    1: tx_q.push_back(32767);
                    default: tx_q.push_back(int'($urandom_range(65535)) - 32768);
                endcase
            end
            drive(80, int'($urandom_range(100, 20)));
        end
        drive(200, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
